// File: rtl/xor_update_issue_pkg.sv
// Shared constants and request record for the XOR-update issue stage.
// Default widths here also size req_t, so the top's delay line uses them.
package xor_update_issue_pkg;

    localparam int NUM_MUL_DEF     = 4;
    localparam int INDEX_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF  = 64;
    localparam int READ_LAT_DEF    = 2;
    localparam int HAZ_DEPTH       = READ_LAT_DEF + 5;
    localparam int LANE_W          = (NUM_MUL_DEF > 1) ? $clog2(NUM_MUL_DEF) : 1;

    typedef struct packed {
        logic [INDEX_WIDTH_DEF-1:0] index;
        logic [LANE_W-1:0]          lane;
        logic [DATA_WIDTH_DEF-1:0]  data;
    } req_t;

endpackage

// File: rtl/xor_hazard_scoreboard.sv
// Shift register of recently accepted indices with a parallel compare,
// so a read-after-write on the same table row is held off until it commits.
module xor_hazard_scoreboard
    import xor_update_issue_pkg::*;
#(
    parameter int DEPTH       = HAZ_DEPTH,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    input  logic [INDEX_WIDTH-1:0] push_index,
    input  logic [INDEX_WIDTH-1:0] probe_index,
    output logic                   match
);

    logic [DEPTH-1:0]       sb_valid;
    logic [INDEX_WIDTH-1:0] sb_index [DEPTH];

    // NOTE: the index entries are cleared along with the valid bits; only
    // valid gates a match, but clearing keeps post-reset state fully defined.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_valid <= '0;
            for (int i = 0; i < DEPTH; i++) sb_index[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage shift from the
            // pre-edge values, independent of statement order.
            sb_valid    <= {sb_valid[DEPTH-2:0], push_valid};
            sb_index[0] <= push_index;
            for (int i = 1; i < DEPTH; i++) sb_index[i] <= sb_index[i-1];
        end
    end

    // NOTE: the default before the loop keeps this purely combinational.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (sb_valid[i] && (sb_index[i] == probe_index)) match = 1'b1;
    end

endmodule

// File: rtl/xor_update_issue.sv
// Request front end for the per-lane XOR-hash table: issues the read, XORs the
// returned lane word with the request data and drives the table write side.
module xor_update_issue
    import xor_update_issue_pkg::*;
#(
    parameter int NUM_MUL     = NUM_MUL_DEF,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int READ_LAT    = READ_LAT_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INDEX_WIDTH-1:0]        in_index,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [INDEX_WIDTH-1:0]        rd_index,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] rd_out_update,
    output logic                          write_reg_0_valid,
    output logic [INDEX_WIDTH-1:0]        write_reg_0_index,
    output logic [NUM_MUL*DATA_WIDTH-1:0] write_reg_11_xor,
    output logic [NUM_MUL-1:0]            arbiter_result,
    output logic [31:0]                   stall_cnt
);

    logic                   accept;
    logic                   haz_match;
    logic [LANE_W-1:0]      rr_ptr;
    logic [INDEX_WIDTH-1:0] rd_index_q;

    // Stage k holds a request accepted k+1 cycles ago.
    logic [READ_LAT-1:0]    dl_valid;
    req_t                   dl_req [READ_LAT];

    logic [NUM_MUL*DATA_WIDTH-1:0] wr_xor_next;
    logic [NUM_MUL-1:0]            arb_next;

    xor_hazard_scoreboard #(
        .DEPTH       (READ_LAT + 5),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (accept),
        .push_index  (in_index),
        .probe_index (in_index),
        .match       (haz_match)
    );

    assign in_ready = !reset && !(in_valid && haz_match);
    assign accept   = in_valid && in_ready;
    assign rd_index = accept ? in_index : rd_index_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_index_q <= '0;
            rr_ptr     <= '0;
            stall_cnt  <= '0;
        end else begin
            rd_index_q <= rd_index;
            if (accept)
                rr_ptr <= (rr_ptr == LANE_W'(NUM_MUL - 1)) ? '0 : rr_ptr + 1'b1;
            if (in_valid && !in_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_valid <= '0;
            for (int k = 0; k < READ_LAT; k++) dl_req[k] <= '0;
        end else begin
            dl_valid[0] <= accept;
            dl_req[0]   <= '{index: in_index, lane: rr_ptr, data: in_data};
            for (int k = 1; k < READ_LAT; k++) begin
                dl_valid[k] <= dl_valid[k-1];
                dl_req[k]   <= dl_req[k-1];
            end
        end
    end

    // The table's index pipeline runs two cycles ahead of its data pipeline.
    generate
        if (READ_LAT >= 2) begin : g_wr0_from_line
            assign write_reg_0_valid = dl_valid[READ_LAT-2];
            assign write_reg_0_index = dl_req[READ_LAT-2].index;
        end else begin : g_wr0_from_accept
            assign write_reg_0_valid = accept;
            assign write_reg_0_index = rd_index;
        end
    endgenerate

    // Read data lands with the last delay stage; only the selected lane is written.
    always_comb begin
        wr_xor_next = '0;
        arb_next    = '0;
        for (int l = 0; l < NUM_MUL; l++) begin
            if (dl_valid[READ_LAT-1] && (dl_req[READ_LAT-1].lane == LANE_W'(l))) begin
                arb_next[l] = 1'b1;
                wr_xor_next[l*DATA_WIDTH +: DATA_WIDTH] =
                    rd_out_update[l*DATA_WIDTH +: DATA_WIDTH] ^ dl_req[READ_LAT-1].data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_reg_11_xor <= '0;
            arbiter_result   <= '0;
        end else begin
            write_reg_11_xor <= wr_xor_next;
            arbiter_result   <= arb_next;
        end
    end

endmodule

// File: tb/tb_xor_update_issue.sv
// Bench for xor_update_issue: a behavioural table plus a request-level model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_xor_update_issue;
    import xor_update_issue_pkg::*;

    localparam int NM  = 4;
    localparam int IW  = 12;
    localparam int DW  = 64;
    localparam int RL  = 2;
    localparam int HAZ = RL + 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IW-1:0]     in_index = '0;
    logic [DW-1:0]     in_data = '0;
    logic [IW-1:0]     rd_index;
    logic [NM*DW-1:0]  rd_out_update;
    logic              write_reg_0_valid;
    logic [IW-1:0]     write_reg_0_index;
    logic [NM*DW-1:0]  write_reg_11_xor;
    logic [NM-1:0]     arbiter_result;
    logic [31:0]       stall_cnt;

    xor_update_issue #(
        .NUM_MUL(NM), .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .READ_LAT(RL)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_index          (in_index),
        .in_data           (in_data),
        .rd_index          (rd_index),
        .rd_out_update     (rd_out_update),
        .write_reg_0_valid (write_reg_0_valid),
        .write_reg_0_index (write_reg_0_index),
        .write_reg_11_xor  (write_reg_11_xor),
        .arbiter_result    (arbiter_result),
        .stall_cnt         (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lane_of(input logic [NM-1:0] oh);
        int r = 0;
        for (int l = 0; l < NM; l++) if (oh[l]) r = l;
        return r;
    endfunction

    // Table: READ_LAT read, write index two cycles before data, commit 4 cycles later.
    logic [NM*DW-1:0] tbl [4096];
    logic [NM*DW-1:0] rd_pipe [RL];
    logic [IW-1:0]    wr0_h [2];
    logic             wp_v [4];
    logic [IW-1:0]    wp_idx [4];
    int               wp_lane [4];
    logic [DW-1:0]    wp_data [4];

    assign rd_out_update = rd_pipe[RL-1];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) tbl[i] <= '0;
            for (int k = 0; k < RL; k++) rd_pipe[k] <= '0;
            for (int k = 0; k < 4; k++) wp_v[k] <= 1'b0;
            wr0_h[0] <= '0;
            wr0_h[1] <= '0;
        end else begin
            rd_pipe[0] <= tbl[rd_index];
            for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
            if (wp_v[3]) tbl[wp_idx[3]][wp_lane[3]*DW +: DW] <= wp_data[3];
            wr0_h[0]   <= write_reg_0_index;
            wr0_h[1]   <= wr0_h[0];
            wp_v[0]    <= |arbiter_result;
            wp_idx[0]  <= wr0_h[1];
            wp_lane[0] <= lane_of(arbiter_result);
            wp_data[0] <= write_reg_11_xor[lane_of(arbiter_result)*DW +: DW];
            for (int k = 1; k < 4; k++) begin
                wp_v[k]    <= wp_v[k-1];
                wp_idx[k]  <= wp_idx[k-1];
                wp_lane[k] <= wp_lane[k-1];
                wp_data[k] <= wp_data[k-1];
            end
        end
    end

    // Request-level model: accepted history, lane counter, XOR memory, scheduled events.
    typedef struct { int idx; int cyc; } hist_t;
    hist_t          hist [$];
    int             m_ptr = 0;
    logic [IW-1:0]  m_rd = '0;
    logic [31:0]    m_stall = '0;
    logic [DW-1:0]  m_mem [int];
    int             ev_wr0 [int];
    int             ev_lane [int];
    logic [DW-1:0]  ev_data [int];
    logic [NM-1:0]  arb_log [$];
    logic [DW-1:0]  data_log [$];
    int             wr0_cnt = 0;

    bit             hz;
    bit             exp_ready;
    int             key;
    logic [DW-1:0]  nv;

    always @(negedge clk) begin
        if (|arbiter_result) begin
            arb_log.push_back(arbiter_result);
            data_log.push_back(write_reg_11_xor[lane_of(arbiter_result)*DW +: DW]);
        end
        if (write_reg_0_valid) wr0_cnt++;

        if (reset) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_rd_index", rd_index, 0);
            check("rst_wr0_valid", write_reg_0_valid, 0);
            check("rst_wr0_index", write_reg_0_index, 0);
            check("rst_arbiter", arbiter_result, 0);
            check("rst_xor_nonzero", |write_reg_11_xor, 0);
            check("rst_stall_cnt", stall_cnt, 0);
            hist.delete();
            m_mem.delete();
            ev_wr0.delete();
            ev_lane.delete();
            ev_data.delete();
            m_ptr   = 0;
            m_rd    = '0;
            m_stall = '0;
        end else begin
            hz = 1'b0;
            foreach (hist[i])
                if (hist[i].idx == int'(in_index) && cyc - hist[i].cyc <= HAZ) hz = 1'b1;
            exp_ready = !(in_valid && hz);
            check("in_ready", in_ready, exp_ready);
            check("stall_cnt", stall_cnt, m_stall);
            if (in_valid && !exp_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (in_valid && exp_ready) begin
                key = int'(in_index) * NM + m_ptr;
                nv  = (m_mem.exists(key) ? m_mem[key] : '0) ^ in_data;
                m_mem[key]        = nv;
                ev_wr0[cyc+RL-1]  = int'(in_index);
                ev_lane[cyc+RL+1] = m_ptr;
                ev_data[cyc+RL+1] = nv;
                hist.push_back('{int'(in_index), cyc});
                m_ptr = (m_ptr + 1) % NM;
                m_rd  = in_index;
            end
            check("rd_index", rd_index, m_rd);
            if (ev_wr0.exists(cyc)) begin
                check("wr0_valid", write_reg_0_valid, 1);
                check("wr0_index", write_reg_0_index, ev_wr0[cyc]);
                ev_wr0.delete(cyc);
            end else begin
                check("wr0_idle", write_reg_0_valid, 0);
            end
            if (ev_lane.exists(cyc)) begin
                check("arbiter", arbiter_result, 64'(1) << ev_lane[cyc]);
                check("xor_data", write_reg_11_xor[ev_lane[cyc]*DW +: DW], ev_data[cyc]);
                ev_lane.delete(cyc);
                ev_data.delete(cyc);
            end else begin
                check("arbiter_idle", arbiter_result, 0);
            end
            while (hist.size() > 0 && cyc - hist[0].cyc > HAZ) void'(hist.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic clear_logs();
        arb_log.delete();
        data_log.delete();
        wr0_cnt = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // Presents a request until accepted; inputs stay driven afterwards.
    task automatic send(input logic [IW-1:0] idx, input logic [DW-1:0] d, output int t_acc);
        t_acc    = -1;
        in_valid = 1'b1;
        in_index = idx;
        in_data  = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (in_ready) begin
                t_acc = cyc;
                break;
            end
            tick();
        end
        check("accept_within_bound", t_acc >= 0, 1);
        tick();
    endtask

    int            ta, tb2, t_unused;
    logic [NM-1:0] exp_arb [5];
    logic [DW-1:0] exp_dat [5];

    initial begin
        tick();
        do_reset();

        // Single request.
        in_valid = 1'b1; in_index = 12'h005; in_data = 64'hFF;
        @(negedge clk);
        check("single_ready", in_ready, 1);
        check("single_rd_index", rd_index, 12'h005);
        tick();
        idle();
        @(negedge clk);
        check("single_wr0_valid", write_reg_0_valid, 1);
        check("single_wr0_index", write_reg_0_index, 12'h005);
        @(negedge clk);
        @(negedge clk);
        check("single_arbiter", arbiter_result, 4'b0001);
        check("single_lane0", write_reg_11_xor[DW-1:0], 64'hFF);
        tick();

        // Back-to-back distinct indices.
        do_reset();
        clear_logs();
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_index = IW'(i); in_data = {$urandom, $urandom};
            @(negedge clk);
            check("b2b_ready", in_ready, 1);
            tick();
        end
        idle();
        repeat (8) tick();
        exp_arb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("b2b_write_count", arb_log.size(), 5);
        for (int i = 0; i < 5 && i < arb_log.size(); i++) check("b2b_arbiter_seq", arb_log[i], exp_arb[i]);
        check("b2b_stall_cnt", stall_cnt, 0);

        // Same index twice.
        do_reset();
        send(12'h010, 64'h1, ta);
        send(12'h010, 64'h2, tb2);
        idle();
        check("hazard_accept_gap", tb2 - ta, 8);
        check("hazard_stall_cnt", stall_cnt, 7);
        repeat (8) tick();

        // Repeated index accumulating across lanes.
        do_reset();
        clear_logs();
        send(12'h020, 64'd1, t_unused);
        send(12'h020, 64'd2, t_unused);
        send(12'h020, 64'd4, t_unused);
        send(12'h020, 64'd8, t_unused);
        send(12'h020, 64'd16, t_unused);
        idle();
        repeat (8) tick();
        exp_arb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_dat = '{64'h1, 64'h2, 64'h4, 64'h8, 64'h11};
        check("accum_write_count", arb_log.size(), 5);
        for (int i = 0; i < 5 && i < arb_log.size(); i++) begin
            check("accum_arbiter", arb_log[i], exp_arb[i]);
            check("accum_data", data_log[i], exp_dat[i]);
        end

        // Reset mid-flight.
        do_reset();
        send(12'h030, 64'hABCD, ta);
        idle();
        tick();
        reset = 1'b1;
        clear_logs();
        repeat (3) tick();
        reset = 1'b0; in_valid = 1'b1; in_index = 12'h030; in_data = 64'h5;
        @(negedge clk);
        check("post_reset_ready", in_ready, 1);
        check("post_reset_no_arb", arb_log.size(), 0);
        check("post_reset_no_wr0", wr0_cnt, 0);
        tick();
        idle();
        repeat (6) tick();
        check("post_reset_write_count", arb_log.size(), 1);
        if (arb_log.size() > 0) check("post_reset_ptr_lane0", arb_log[0], 4'b0001);

        // Random traffic with a narrow index set to provoke hazards.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_index = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 4095)) : IW'($urandom_range(0, 7));
            in_data  = {$urandom, $urandom};
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        idle();
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
